// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register: loads a word on set, emits it
// LSB-first on bit_out one bit per shift strobe, and counts unsent bits.
module piso_shift_reg #(
    parameter int unsigned M    = 10,
    parameter logic        FILL = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [M-1:0]               bus_in,
    input  logic                       set,
    input  logic                       shift,
    output logic                       bit_out,
    output logic [$clog2(M+1)-1:0]     bits_left,
    output logic                       empty
);

    localparam int unsigned CW = $clog2(M + 1);

    logic [M-1:0]  sr;
    logic [M-1:0]  sr_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          empty_q;

    // Next-state: load beats shift beats hold; count saturates at zero.
    always_comb begin
        sr_next  = sr;
        cnt_next = cnt;
        if (set) begin
            sr_next  = bus_in;
            cnt_next = CW'(M);
        end else if (shift) begin
            sr_next = {FILL, sr[M-1:1]};
            if (cnt != '0) begin
                cnt_next = cnt - CW'(1);
            end
        end
    end

    // State registers; empty is kept as its own flop so it is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr      <= {M{FILL}};
            cnt     <= '0;
            empty_q <= 1'b1;
        end else begin
            sr      <= sr_next;
            cnt     <= cnt_next;
            empty_q <= (cnt_next == '0);
        end
    end

    assign bit_out   = sr[0];
    assign bits_left = cnt;
    assign empty     = empty_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed self-checking bench for piso_shift_reg at M=10.
module tb_piso_shift_reg;

    localparam int unsigned M  = 10;
    localparam int unsigned CW = $clog2(M + 1);

    logic          clk;
    logic          reset;
    logic [M-1:0]  bus_in;
    logic          set;
    logic          shift;
    logic          bit_out;
    logic [CW-1:0] bits_left;
    logic          empty;

    int n_assert;
    int n_fail;

    piso_shift_reg #(.M(M), .FILL(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .set       (set),
        .shift     (shift),
        .bit_out   (bit_out),
        .bits_left (bits_left),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic eb, input int el, input logic ee);
        check({tag, ".bit_out"}, 32'(bit_out), 32'(eb));
        check({tag, ".bits_left"}, 32'(bits_left), 32'(el));
        check({tag, ".empty"}, 32'(empty), 32'(ee));
    endtask

    // One clock with the given strobes; inputs drop back to idle 1ns after the edge.
    task automatic cycle(input logic s, input logic sh, input logic [M-1:0] d);
        set    = s;
        shift  = sh;
        bus_in = d;
        @(posedge clk);
        #1;
        set    = 1'b0;
        shift  = 1'b0;
        bus_in = $urandom();
    endtask

    initial begin
        logic [M-1:0] word;
        int           k;
        n_assert = 0;
        n_fail   = 0;
        reset  = 1'b1;
        set    = 1'b0;
        shift  = 1'b0;
        bus_in = '0;

        // 1. asynchronous reset asserted mid-cycle
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_out("reset_async", 1'b1, 0, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 check_out("reset_idle", 1'b1, 0, 1'b1);

        // 2. load 10'h34A and shift once every 4 cycles
        word = 10'h34A;
        cycle(1'b1, 1'b0, word);
        check_out("ser_load", 1'b0, 10, 1'b0);
        for (k = 1; k <= 10; k++) begin
            cycle(1'b0, 1'b1, '0);
            check_out($sformatf("ser_shift%0d", k),
                      (k < 10) ? word[k] : 1'b1, 10 - k, (k == 10));
            repeat (3) cycle(1'b0, 1'b0, '0);
        end
        check_out("ser_idle", 1'b1, 0, 1'b1);

        // 3. set and shift together: set wins
        cycle(1'b1, 1'b0, 10'h34A);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);
        check_out("both_pre", 1'b0, 8, 1'b0);
        cycle(1'b1, 1'b1, 10'h001);
        check_out("both_set", 1'b1, 10, 1'b0);
        cycle(1'b0, 1'b1, '0);
        check_out("both_next", 1'b0, 9, 1'b0);

        // 4. over-shift an all-zero word
        cycle(1'b1, 1'b0, 10'h000);
        check_out("over_load", 1'b0, 10, 1'b0);
        for (k = 1; k <= 13; k++) begin
            cycle(1'b0, 1'b1, '0);
            check_out($sformatf("over_shift%0d", k),
                      (k >= 10), (k >= 10) ? 0 : 10 - k, (k >= 10));
        end

        // 5. reset in the middle of a transfer
        cycle(1'b1, 1'b0, 10'h2AA);
        repeat (3) cycle(1'b0, 1'b1, '0);
        check_out("mid_pre", 1'b1, 7, 1'b0);
        #2 reset = 1'b0;
        #1 check_out("mid_reset", 1'b1, 0, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 10'h000);
        check_out("mid_after", 1'b1, 0, 1'b1);
        cycle(1'b0, 1'b1, '0);
        check_out("mid_after_shift", 1'b1, 0, 1'b1);

        // 6. hold for 20 cycles
        cycle(1'b1, 1'b0, 10'h155);
        repeat (20) cycle(1'b0, 1'b0, '0);
        check_out("hold", 1'b1, 10, 1'b0);
        cycle(1'b0, 1'b1, '0);
        check_out("hold_shift", 1'b0, 9, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
